// File: rtl/issue_queue_if.sv
// rtl/issue_queue_if.sv - dispatch-in / issue-out handshake bundle for issue_queue
//
// Signals:
//   instr, input_valid, input_ready     : dispatch side (rename -> queue)
//   instr_out, output_valid, output_ready : issue side (queue -> functional unit)
// Modports:
//   slave  : the queue itself
//   master : the environment driving dispatch and consuming issue
interface issue_queue_if #(
    parameter int INST_WIDTH = 47
) ();
    logic [INST_WIDTH-1:0] instr;
    logic                  input_valid;
    logic                  input_ready;
    logic [INST_WIDTH-1:0] instr_out;
    logic                  output_valid;
    logic                  output_ready;

    modport slave (
        input  instr,
        input  input_valid,
        output input_ready,
        output instr_out,
        output output_valid,
        input  output_ready
    );

    modport master (
        output instr,
        output input_valid,
        input  input_ready,
        input  instr_out,
        input  output_valid,
        output output_ready
    );
endinterface

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - compacting issue queue with tag-broadcast wakeup
//
// Holds up to DEPTH renamed instructions, entry 0 oldest. Source ready bits are
// woken combinationally from done_flags and written back every edge (sticky).
// One instruction issues per cycle: oldest fully-ready entry (IN_ORDER=0) or
// the head only (IN_ORDER=1). Issued entries are squeezed out by shifting the
// younger entries down one slot.
//
// Ports:
//   clk         clock, all state on rising edge
//   rst         synchronous reset, active low
//   flush       synchronous clear of all entries; suppresses enqueue/issue
//   done_flags  bit t set: tag t result available this cycle
//   bus         issue_queue_if.slave: instr/input_valid/input_ready in,
//               instr_out/output_valid/output_ready out
//   count       number of occupied entries
module issue_queue #(
    parameter int INST_WIDTH = 47,
    parameter int DEPTH      = 4,
    parameter int NUM_SRC    = 4,
    parameter int TAG_W      = 5,
    parameter int TAG_LSB    = 13,
    parameter int RDY_LSB    = 9,
    parameter int NUM_TAGS   = 10,
    parameter bit IN_ORDER   = 1'b0,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [NUM_TAGS-1:0]  done_flags,
    issue_queue_if.slave         bus,
    output logic [CNT_W-1:0]     count
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [INST_WIDTH-1:0] entries_q [DEPTH];
    logic [INST_WIDTH-1:0] entries_d [DEPTH];
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;

    logic [INST_WIDTH-1:0] eff [DEPTH];
    logic [DEPTH-1:0]      rdy;
    logic [INST_WIDTH-1:0] new_word;
    logic                  active;
    logic                  sel_found;
    int                    sel_idx;
    int                    base;
    logic                  out_valid;
    logic                  in_rdy;
    logic                  iss;
    logic                  enq;

    // Set each source's ready bit when its tag is broadcast this cycle.
    // Tags at or beyond NUM_TAGS have no done_flags bit and never match.
    function automatic logic [INST_WIDTH-1:0] wake(
        input logic [INST_WIDTH-1:0] w,
        input logic [NUM_TAGS-1:0]   df
    );
        logic [INST_WIDTH-1:0] r;
        logic [TAG_W-1:0]      tag;
        r = w;
        for (int i = 0; i < NUM_SRC; i++) begin
            tag = w[TAG_LSB + TAG_W*i +: TAG_W];
            for (int t = 0; t < NUM_TAGS; t++) begin
                if ((int'(tag) == t) && df[t]) begin
                    r[RDY_LSB + i] = 1'b1;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        active    = rst & ~flush;
        sel_found = 1'b0;
        sel_idx   = 0;

        for (int j = 0; j < DEPTH; j++) begin
            eff[j] = wake(entries_q[j], done_flags);
            rdy[j] = (j < int'(count_q)) && (&eff[j][RDY_LSB +: NUM_SRC]);
        end

        if (IN_ORDER) begin
            sel_found = rdy[0];
        end else begin
            // Walk from youngest to oldest so the last hit is the oldest ready.
            for (int j = DEPTH - 1; j >= 0; j--) begin
                if (rdy[j]) begin
                    sel_found = 1'b1;
                    sel_idx   = j;
                end
            end
        end

        out_valid        = active & sel_found;
        bus.output_valid = out_valid;
        bus.instr_out    = out_valid ? eff[sel_idx] : '0;
        iss              = out_valid & bus.output_ready;

        // A full queue still accepts when it is issuing this cycle.
        in_rdy          = active & ((count_q < DEPTH_C) | iss);
        bus.input_ready = in_rdy;
        enq             = bus.input_valid & in_rdy;

        new_word = wake(bus.instr, done_flags);
        base     = int'(count_q) - (iss ? 1 : 0);

        // Entries at/above the issued slot take their younger neighbour's
        // woken word; the new instruction lands just past the survivors.
        for (int j = 0; j < DEPTH; j++) begin
            if (iss && (j >= sel_idx)) begin
                entries_d[j] = (j < DEPTH - 1) ? eff[(j + 1) % DEPTH] : '0;
            end else begin
                entries_d[j] = eff[j];
            end
            if (enq && (j == base)) begin
                entries_d[j] = new_word;
            end
        end

        count_d = count_q + {{(CNT_W-1){1'b0}}, enq} - {{(CNT_W-1){1'b0}}, iss};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                entries_q[j] <= '0;
            end
        end else begin
            if (flush) begin
                count_q <= '0;
            end else begin
                count_q <= count_d;
            end
            for (int j = 0; j < DEPTH; j++) begin
                entries_q[j] <= entries_d[j];
            end
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - bench for issue_queue, out-of-order and in-order instances
module tb_issue_queue;

    typedef logic [46:0] wq_t [$];

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [9:0]  df;
    logic [46:0] instr;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  c0;
    logic [2:0]  c1;

    int tests = 0;
    int fails = 0;

    wq_t q0;
    wq_t q1;

    always #5 clk = ~clk;

    issue_queue_if #(.INST_WIDTH(47)) bus0 ();
    issue_queue_if #(.INST_WIDTH(47)) bus1 ();

    assign bus0.instr        = instr;
    assign bus0.input_valid  = in_valid;
    assign bus0.output_ready = out_ready;
    assign bus1.instr        = instr;
    assign bus1.input_valid  = in_valid;
    assign bus1.output_ready = out_ready;

    issue_queue #(.IN_ORDER(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .done_flags(df), .bus(bus0.slave), .count(c0)
    );
    issue_queue #(.IN_ORDER(1'b1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .done_flags(df), .bus(bus1.slave), .count(c1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference wakeup: source i's tag lives at 13+5i, its ready bit at 9+i.
    function automatic logic [46:0] wake(input logic [46:0] w, input logic [9:0] f);
        logic [46:0] r;
        int tg;
        r = w;
        for (int i = 0; i < 4; i++) begin
            tg = int'(w[13 + 5*i +: 5]);
            if (tg < 10 && f[tg]) r[9 + i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [46:0] mk(input int t0, input int t1, input int t2, input int t3,
                                       input logic [3:0] r);
        logic [46:0] w;
        w = {$urandom, $urandom};
        w[13 +: 5] = 5'(t0);
        w[18 +: 5] = 5'(t1);
        w[23 +: 5] = 5'(t2);
        w[28 +: 5] = 5'(t3);
        w[12:9]    = r;
        return w;
    endfunction

    task automatic eval(input wq_t q, input bit inord, output bit ov, output logic [46:0] io,
                        output bit ir, output int sel);
        logic [46:0] e;
        ov = 1'b0; io = '0; ir = 1'b0; sel = -1;
        if (rst && !flush) begin
            for (int k = 0; k < q.size(); k++) begin
                e = wake(q[k], df);
                if (sel < 0 && (!inord || k == 0) && (&e[12:9])) sel = k;
            end
            ov = (sel >= 0);
            if (ov) io = wake(q[sel], df);
            ir = (q.size() < 4) || (ov && out_ready);
        end
    endtask

    task automatic nxt(input wq_t q, input bit inord, output wq_t nq);
        bit ov, ir;
        logic [46:0] io;
        int sel;
        eval(q, inord, ov, io, ir, sel);
        nq = {};
        if (rst && !flush) begin
            foreach (q[k]) nq.push_back(wake(q[k], df));
            if (ov && out_ready) nq.delete(sel);
            if (in_valid && ir) nq.push_back(wake(instr, df));
        end
    endtask

    // Called just after a negedge with inputs set: checks all outputs of both
    // instances against the model, then advances model and DUTs one edge.
    task automatic step();
        bit ov, ir;
        logic [46:0] io;
        int sel;
        wq_t n0, n1;
        #1;
        eval(q0, 1'b0, ov, io, ir, sel);
        chk("ooo_output_valid", 64'(bus0.output_valid), 64'(ov));
        chk("ooo_instr_out",    64'(bus0.instr_out),    64'(io));
        chk("ooo_input_ready",  64'(bus0.input_ready),  64'(ir));
        chk("ooo_count",        64'(c0),                64'(q0.size()));
        eval(q1, 1'b1, ov, io, ir, sel);
        chk("ino_output_valid", 64'(bus1.output_valid), 64'(ov));
        chk("ino_instr_out",    64'(bus1.instr_out),    64'(io));
        chk("ino_input_ready",  64'(bus1.input_ready),  64'(ir));
        chk("ino_count",        64'(c1),                64'(q1.size()));
        @(posedge clk);
        nxt(q0, 1'b0, n0);
        nxt(q1, 1'b1, n1);
        q0 = n0;
        q1 = n1;
        @(negedge clk);
    endtask

    initial begin
        logic [46:0] w0, w1, w2, w3, wn;

        rst = 1'b0; flush = 1'b0; df = '0; instr = '0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset held with a valid dispatch pending.
        instr = mk(31, 31, 31, 31, 4'hF); in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rst_input_ready", 64'(bus0.input_ready), 64'd0);
            chk("rst_output_valid", 64'(bus0.output_valid), 64'd0);
            step();
        end
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_count", 64'(c0), 64'd0);
        chk("rel_input_ready", 64'(bus0.input_ready), 64'd1);
        step();

        // Wakeup over two broadcasts, tags {3,5,7,9}.
        instr = mk(3, 5, 7, 9, 4'h0); in_valid = 1'b1;
        step();
        in_valid = 1'b0; df = 10'h0A8;
        #1;
        chk("wake_partial_valid", 64'(bus0.output_valid), 64'd0);
        step();
        df = 10'h200;
        #1;
        chk("wake_full_valid", 64'(bus0.output_valid), 64'd1);
        chk("wake_rdy_bits", 64'(bus0.instr_out[12:9]), 64'hF);
        step();
        df = '0; out_ready = 1'b1;
        step();

        // Ready on arrival still waits one cycle.
        instr = mk(31, 31, 31, 31, 4'hF); in_valid = 1'b1;
        #1;
        chk("enq_cycle_no_issue", 64'(bus0.output_valid), 64'd0);
        step();
        in_valid = 1'b0;
        #1;
        chk("next_cycle_issue", 64'(bus0.output_valid), 64'd1);
        step();

        // Out-of-order select with entries 1 and 3 ready.
        out_ready = 1'b0; in_valid = 1'b1;
        w0 = mk(2, 2, 2, 2, 4'h0);
        w1 = mk(31, 31, 31, 31, 4'hF);
        w2 = mk(31, 31, 31, 31, 4'h0);
        w3 = mk(31, 31, 31, 31, 4'hF);
        instr = w0; step();
        instr = w1; step();
        instr = w2; step();
        instr = w3; step();
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("ooo_first", 64'(bus0.instr_out), 64'(w1));
        chk("ino_head_blocked", 64'(bus1.output_valid), 64'd0);
        step();
        #1;
        chk("ooo_second", 64'(bus0.instr_out), 64'(w3));
        step();
        #1;
        chk("ooo_count_two", 64'(c0), 64'd2);
        chk("ino_still_blocked", 64'(bus1.output_valid), 64'd0);
        // Waking the head releases the in-order queue.
        df = 10'h004;
        #1;
        chk("ino_head_woken", 64'(bus1.output_valid), 64'd1);
        chk("ino_head_word", 64'(bus1.instr_out), 64'({w0[46:13], 4'hF, w0[8:0]}));
        step();
        df = '0; flush = 1'b1;
        step();
        flush = 1'b0;

        // Full queue: issue and enqueue in the same cycle.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instr = mk(31, 31, 31, 31, 4'hF);
            step();
        end
        wn = mk(31, 31, 31, 31, 4'hF); instr = wn; out_ready = 1'b1;
        #1;
        chk("full_ooo_input_ready", 64'(bus0.input_ready), 64'd1);
        chk("full_ino_input_ready", 64'(bus1.input_ready), 64'd1);
        step();
        in_valid = 1'b0;
        #1;
        chk("full_count_held", 64'(c0), 64'd4);
        step(); step(); step();
        #1;
        chk("full_new_at_tail", 64'(bus0.instr_out), 64'(wn));
        step();

        // Flush with pending wakeup and a valid dispatch.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr = mk(4, 4, 4, 4, 4'h0);
            step();
        end
        flush = 1'b1; df = 10'h010; out_ready = 1'b1;
        #1;
        chk("flush_output_valid", 64'(bus0.output_valid), 64'd0);
        chk("flush_input_ready", 64'(bus0.input_ready), 64'd0);
        step();
        flush = 1'b0; df = '0; in_valid = 1'b0;
        #1;
        chk("flush_count", 64'(c0), 64'd0);
        chk("flush_no_valid", 64'(bus0.output_valid), 64'd0);
        step();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 99) >= 2);
            flush     = ($urandom_range(0, 99) < 3);
            df        = 10'($urandom & $urandom & $urandom);
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 60);
            instr     = mk($urandom_range(0, 11), $urandom_range(0, 11),
                           $urandom_range(0, 11), $urandom_range(0, 11), 4'($urandom));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
